// File: rtl/ldl_hot2bin_pipe.sv
// Pipelined one-hot to binary encoder with valid/ready on both sides.
// Non-one-hot words are flagged and counted (saturating) when they are accepted.
module ldl_hot2bin_pipe #(
  parameter int BIN_WIDTH = 8,
  parameter int PIPE      = 2,
  parameter int CNT_WIDTH = 16,
  localparam int HOT_W    = 1 << BIN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [HOT_W-1:0]     in_hot,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [BIN_WIDTH-1:0] out_bin,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int P_SAFE = (PIPE < 1) ? 1 : PIPE;
  localparam int BPS    = (BIN_WIDTH + P_SAFE - 1) / P_SAFE;

  if (PIPE < 1 || PIPE > BIN_WIDTH) begin : g_badPipe
    $error("ldl_hot2bin_pipe: PIPE=%0d outside legal range 1..%0d", PIPE, BIN_WIDTH);
  end

  // OR together every hot position whose index has bit b set, for bits lo..hi-1 only.
  function automatic logic [BIN_WIDTH-1:0] resolveBits(
    input logic [HOT_W-1:0]     hot,
    input logic [BIN_WIDTH-1:0] binIn,
    input int                   lo,
    input int                   hi
  );
    logic [BIN_WIDTH-1:0] res;
    res = binIn;
    for (int b = 0; b < BIN_WIDTH; b++) begin
      if (b >= lo && b < hi) begin
        res[b] = 1'b0;
        for (int j = 0; j < HOT_W; j++) begin
          if (j[b]) res[b] = res[b] | hot[j];
        end
      end
    end
    return res;
  endfunction

  logic                 w_accept;
  logic                 w_inErr;
  logic [HOT_W-1:0]     w_inIso;
  logic [PIPE-1:0]      w_stVld;
  logic [PIPE-1:0]      w_stRdy;
  logic [PIPE-1:0]      w_inVld;
  logic [PIPE-1:0]      w_errIn;
  logic [HOT_W-1:0]     w_hotIn [PIPE];
  logic [BIN_WIDTH-1:0] w_binIn [PIPE];
  logic [CNT_WIDTH-1:0] r_errCnt;

  assign in_rdy   = w_stRdy[0] & ~rst;
  assign w_accept = in_vld & in_rdy;

  // Keeping only the lowest set bit makes multi-hot words encode to their lowest index.
  assign w_inIso = in_hot & (~in_hot + HOT_W'(1));
  assign w_inErr = (in_hot == '0) | ((in_hot & (in_hot - HOT_W'(1))) != '0);

  assign w_inVld[0] = w_accept;
  assign w_hotIn[0] = w_inIso;
  assign w_binIn[0] = '0;
  assign w_errIn[0] = w_inErr;

  assign out_vld = w_stVld[PIPE-1];
  assign err_cnt = r_errCnt;

  for (genvar s = 0; s < PIPE; s++) begin : g_stage
    localparam int LO = s * BPS;
    localparam int HI = ((s + 1) * BPS > BIN_WIDTH) ? BIN_WIDTH : (s + 1) * BPS;

    logic                 r_vld;
    logic                 r_err;
    logic [BIN_WIDTH-1:0] r_bin;

    // A stage can load when it or any stage downstream of it has a free slot, or the sink drains.
    assign w_stRdy[s] = out_rdy | ~(&w_stVld[PIPE-1:s]);
    assign w_stVld[s] = r_vld;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
        r_err <= 1'b0;
        r_bin <= '0;
      end else if (w_stRdy[s]) begin
        r_vld <= w_inVld[s];
        if (w_inVld[s]) begin
          r_bin <= resolveBits(w_hotIn[s], w_binIn[s], LO, HI);
          r_err <= w_errIn[s];
        end
      end
    end

    if (s < PIPE - 1) begin : g_fwd
      logic [HOT_W-1:0] r_hot;

      always_ff @(posedge clk) begin
        if (w_stRdy[s] && w_inVld[s]) r_hot <= w_hotIn[s];
      end

      assign w_inVld[s+1] = r_vld;
      assign w_hotIn[s+1] = r_hot;
      assign w_binIn[s+1] = r_bin;
      assign w_errIn[s+1] = r_err;
    end else begin : g_last
      assign out_bin = r_bin;
      assign out_err = r_err;
    end
  end

  // Counted at acceptance; a clear in the same cycle wins over the increment.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_errCnt <= '0;
    end else if (w_accept && w_inErr && (r_errCnt != {CNT_WIDTH{1'b1}})) begin
      r_errCnt <= r_errCnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ldl_hot2bin_pipe.sv
// Bench for ldl_hot2bin_pipe: four instances (PIPE=2, PIPE=1, PIPE=8, CNT_WIDTH=2) share stimulus
// and are each checked against a word-level model of an elastic pipeline.
module tb_ldl_hot2bin_pipe;

  localparam int NK = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         inVld;
  logic         outRdy;
  logic         errClr;
  logic [255:0] inHot;

  logic         inRdy   [NK];
  logic         outVld  [NK];
  logic [7:0]   outBin  [NK];
  logic         outErr  [NK];
  logic [15:0]  errCnt16 [3];
  logic [1:0]   errCnt2;

  int nChecks;
  int nFails;

  // Model: each in-flight word with its index, error flag and current stage position.
  logic [7:0] mBin    [NK][8];
  logic       mErr    [NK][8];
  int         mPos    [NK][8];
  int         mCnt    [NK];
  int         mErrCnt [NK];

  always #5 clk = ~clk;

  ldl_hot2bin_pipe #(.BIN_WIDTH(8), .PIPE(2), .CNT_WIDTH(16)) dutP2 (
    .clk(clk), .rst(rst), .in_vld(inVld), .in_rdy(inRdy[0]), .in_hot(inHot),
    .out_vld(outVld[0]), .out_rdy(outRdy), .out_bin(outBin[0]), .out_err(outErr[0]),
    .err_clr(errClr), .err_cnt(errCnt16[0]));

  ldl_hot2bin_pipe #(.BIN_WIDTH(8), .PIPE(1), .CNT_WIDTH(16)) dutP1 (
    .clk(clk), .rst(rst), .in_vld(inVld), .in_rdy(inRdy[1]), .in_hot(inHot),
    .out_vld(outVld[1]), .out_rdy(outRdy), .out_bin(outBin[1]), .out_err(outErr[1]),
    .err_clr(errClr), .err_cnt(errCnt16[1]));

  ldl_hot2bin_pipe #(.BIN_WIDTH(8), .PIPE(8), .CNT_WIDTH(16)) dutP8 (
    .clk(clk), .rst(rst), .in_vld(inVld), .in_rdy(inRdy[2]), .in_hot(inHot),
    .out_vld(outVld[2]), .out_rdy(outRdy), .out_bin(outBin[2]), .out_err(outErr[2]),
    .err_clr(errClr), .err_cnt(errCnt16[2]));

  ldl_hot2bin_pipe #(.BIN_WIDTH(8), .PIPE(2), .CNT_WIDTH(2)) dutC2 (
    .clk(clk), .rst(rst), .in_vld(inVld), .in_rdy(inRdy[3]), .in_hot(inHot),
    .out_vld(outVld[3]), .out_rdy(outRdy), .out_bin(outBin[3]), .out_err(outErr[3]),
    .err_clr(errClr), .err_cnt(errCnt2));

  function automatic int pipeOf(input int k);
    return (k == 1) ? 1 : (k == 2) ? 8 : 2;
  endfunction

  function automatic int cntMax(input int k);
    return (k == 3) ? 3 : 65535;
  endfunction

  function automatic logic [7:0] expBin(input logic [255:0] hot);
    for (int i = 0; i < 256; i++) begin
      if (hot[i]) return 8'(i);
    end
    return 8'd0;
  endfunction

  function automatic logic expErr(input logic [255:0] hot);
    return ($countones(hot) != 1);
  endfunction

  function automatic logic [255:0] randHot();
    logic [255:0] h;
    int           m;
    h = '0;
    m = int'($urandom_range(0, 9));
    if (m < 6) begin
      h[$urandom_range(0, 255)] = 1'b1;
    end else if (m == 7) begin
      h[$urandom_range(0, 255)] = 1'b1;
      h[$urandom_range(0, 255)] = 1'b1;
    end else if (m >= 8) begin
      for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom();
    end
    return h;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] errCntOf(input int k);
    if (k == 3) return 32'(errCnt2);
    return 32'(errCnt16[k]);
  endfunction

  // One clock: drive inputs, check every instance before the edge, then advance the model.
  task automatic applyStimulus(input logic vld, input logic [255:0] hot, input logic ordy,
                               input logic clr, input logic rstIn);
    logic       expRdy [NK];
    logic       expVld [NK];
    logic [7:0] tBin [8];
    logic       tErr [8];
    int         tPos [8];
    int         p, n, np, prevNew;
    logic       emit, acc;

    inVld  = vld;
    inHot  = hot;
    outRdy = ordy;
    errClr = clr;
    rst    = rstIn;
    #1;
    for (int k = 0; k < NK; k++) begin
      p         = pipeOf(k);
      expRdy[k] = !rstIn && (ordy || mCnt[k] < p);
      expVld[k] = (mCnt[k] > 0) && (mPos[k][0] == p - 1);
      checkOutput($sformatf("dut%0d in_rdy", k), 32'(inRdy[k]), 32'(expRdy[k]));
      checkOutput($sformatf("dut%0d out_vld", k), 32'(outVld[k]), 32'(expVld[k]));
      if (expVld[k]) begin
        checkOutput($sformatf("dut%0d out_bin", k), 32'(outBin[k]), 32'(mBin[k][0]));
        checkOutput($sformatf("dut%0d out_err", k), 32'(outErr[k]), 32'(mErr[k][0]));
      end
      checkOutput($sformatf("dut%0d err_cnt", k), errCntOf(k), 32'(mErrCnt[k]));
    end

    @(posedge clk);

    for (int k = 0; k < NK; k++) begin
      p = pipeOf(k);
      if (rstIn) begin
        mCnt[k]    = 0;
        mErrCnt[k] = 0;
      end else begin
        emit = expVld[k] && ordy;
        acc  = vld && expRdy[k];
        if (clr) mErrCnt[k] = 0;
        else if (acc && expErr(hot) && mErrCnt[k] < cntMax(k)) mErrCnt[k]++;
        n       = 0;
        prevNew = p;
        for (int i = 0; i < mCnt[k]; i++) begin
          if (i == 0 && emit) begin
            prevNew = p;
          end else begin
            np = mPos[k][i] + 1;
            if (np > p - 1) np = p - 1;
            if (np > prevNew - 1) np = prevNew - 1;
            tBin[n] = mBin[k][i];
            tErr[n] = mErr[k][i];
            tPos[n] = np;
            prevNew = np;
            n++;
          end
        end
        if (acc) begin
          tBin[n] = expBin(hot);
          tErr[n] = expErr(hot);
          tPos[n] = 0;
          n++;
        end
        for (int i = 0; i < n; i++) begin
          mBin[k][i] = tBin[i];
          mErr[k][i] = tErr[i];
          mPos[k][i] = tPos[i];
        end
        mCnt[k] = n;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [255:0] h;
    nChecks = 0;
    nFails  = 0;
    for (int k = 0; k < NK; k++) begin
      mCnt[k]    = 0;
      mErrCnt[k] = 0;
    end
    rst    = 1'b1;
    inVld  = 1'b0;
    inHot  = '0;
    outRdy = 1'b1;
    errClr = 1'b0;
    @(posedge clk);
    @(negedge clk);

    $display("[TB] reset state");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < NK; k++) begin
      checkOutput($sformatf("dut%0d reset out_vld", k), 32'(outVld[k]), 32'd0);
      checkOutput($sformatf("dut%0d reset out_bin", k), 32'(outBin[k]), 32'd0);
      checkOutput($sformatf("dut%0d reset out_err", k), 32'(outErr[k]), 32'd0);
      checkOutput($sformatf("dut%0d reset err_cnt", k), errCntOf(k), 32'd0);
    end

    $display("[TB] one-hot sweep, back-to-back");
    for (int k = 0; k < 256; k++) begin
      h    = '0;
      h[k] = 1'b1;
      applyStimulus(1'b1, h, 1'b1, 1'b0, 1'b0);
    end
    drain(10);
    checkOutput("sweep err_cnt", 32'(errCnt16[0]), 32'd0);

    $display("[TB] zero word then bits 1,3");
    applyStimulus(1'b1, 256'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 256'h0A, 1'b1, 1'b0, 1'b0);
    checkOutput("p2 zero word out_bin", 32'(outBin[0]), 32'd0);
    checkOutput("p2 zero word out_err", 32'(outErr[0]), 32'd1);
    drain(10);
    checkOutput("p2 multi-hot out_bin", 32'(outBin[0]), 32'd1);
    checkOutput("two errors err_cnt", 32'(errCnt16[0]), 32'd2);
    checkOutput("two errors err_cnt small", 32'(errCnt2), 32'd2);

    $display("[TB] stall with out_rdy low");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, randHot(), 1'b0, 1'b0, 1'b0);
    checkOutput("stalled in_rdy p2", 32'(inRdy[0]), 32'd0);
    checkOutput("stalled in_rdy p8", 32'(inRdy[2]), 32'd0);
    drain(12);

    $display("[TB] counter saturation");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i % 2 == 0) ? 256'h0 : 256'h3, 1'b1, 1'b0, 1'b0);
    drain(3);
    checkOutput("saturated err_cnt small", 32'(errCnt2), 32'd3);
    checkOutput("unsaturated err_cnt", 32'(errCnt16[0]), 32'd5);

    $display("[TB] clear beats increment");
    applyStimulus(1'b1, 256'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("clear wins err_cnt", 32'(errCnt16[0]), 32'd0);
    checkOutput("clear wins err_cnt small", 32'(errCnt2), 32'd0);
    drain(10);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, randHot(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0, 1'b0);
    end
    drain(12);

    $display("[TB] reset with words in flight");
    applyStimulus(1'b1, 256'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 256'h5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 256'h0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < NK; k++) begin
      checkOutput($sformatf("dut%0d flush out_vld", k), 32'(outVld[k]), 32'd0);
      checkOutput($sformatf("dut%0d flush err_cnt", k), errCntOf(k), 32'd0);
      checkOutput($sformatf("dut%0d flush out_bin", k), 32'(outBin[k]), 32'd0);
    end
    drain(12);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
